// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps an external round datapath through the initial
// round, the main rounds and the final round of one block encipherment.
// The round datapath is combinational outside this block; this module owns
// the state register, the round-key index and the ciphertext register.
module aes_round_sequencer #(
  parameter int AES128_ROUNDS = 10,
  parameter int AES256_ROUNDS = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  input  logic         key_ready,
  input  logic [127:0] block_in,
  input  logic [127:0] state_new,
  output logic [127:0] state_out,
  output logic [1:0]   round_type,
  output logic [3:0]   round,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    MAIN  = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [1:0] RT_INIT  = 2'd0;
  localparam logic [1:0] RT_MAIN  = 2'd1;
  localparam logic [1:0] RT_FINAL = 2'd2;
  localparam logic [1:0] RT_NONE  = 2'd3;

  localparam logic [3:0] N128 = 4'(AES128_ROUNDS);
  localparam logic [3:0] N256 = 4'(AES256_ROUNDS);

  state_t     state;
  logic [3:0] n_rounds;

  // Idle with a usable key schedule is the only condition that accepts work.
  assign ready = (state == IDLE) && key_ready;

  // Round sequencing FSM; round_type is registered alongside the state so it
  // always describes the round currently presented to the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      state_out    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      round        <= 4'd0;
      round_type   <= RT_NONE;
      n_rounds     <= N128;
    end else begin
      case (state)
        IDLE: begin
          if (next && key_ready) begin
            state_out    <= block_in;
            n_rounds     <= keylen ? N256 : N128;
            round        <= 4'd0;
            result_valid <= 1'b0;
            round_type   <= RT_INIT;
            state        <= INIT;
          end
        end
        INIT: begin
          state_out <= state_new;
          round     <= 4'd1;
          // A one-round schedule skips the main rounds entirely.
          if (n_rounds == 4'd1) begin
            round_type <= RT_FINAL;
            state      <= FINAL;
          end else begin
            round_type <= RT_MAIN;
            state      <= MAIN;
          end
        end
        MAIN: begin
          state_out <= state_new;
          round     <= round + 4'd1;
          // Leaving MAIN when the next index equals N keeps round <= N.
          if (round == n_rounds - 4'd1) begin
            round_type <= RT_FINAL;
            state      <= FINAL;
          end
        end
        FINAL: begin
          result       <= state_new;
          result_valid <= 1'b1;
          round_type   <= RT_NONE;
          state        <= IDLE;
        end
        default: begin
          round_type <= RT_NONE;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter AES128_ROUNDS, default 10, the number of rounds after the initial round for 128-bit keys.
REQ-002 SHALL have parameter AES256_ROUNDS, default 14, the number of rounds after the initial round for 256-bit keys.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port next, input, 1 bit: start-encipher request, sampled each rising edge.
REQ-006 SHALL have port keylen, input, 1 bit: 0 selects AES-128, 1 selects AES-256; sampled only when next is accepted.
REQ-007 SHALL have port key_ready, input, 1 bit: the round-key memory holds a valid expanded key.
REQ-008 SHALL have port block_in, input, 128 bits: plaintext block, sampled only when next is accepted.
REQ-009 SHALL have port state_new, input, 128 bits: combinational result from the round datapath.
REQ-010 SHALL have port state_out, output, 128 bits: state register driven to the round datapath.
REQ-011 SHALL have port round_type, output, 2 bits: 0 INIT, 1 MAIN, 2 FINAL, 3 NONE.
REQ-012 SHALL have port round, output, 4 bits: round-key index for the key memory.
REQ-013 SHALL have port ready, output, 1 bit: the block is idle and able to accept next.
REQ-014 SHALL have port result, output, 128 bits: the last ciphertext.
REQ-015 SHALL have port result_valid, output, 1 bit: result holds a completed ciphertext.

Function
REQ-016 SHALL implement FSM states IDLE, INIT, MAIN, FINAL.
REQ-017 SHALL drive ready = (state==IDLE) & key_ready.
REQ-018 SHALL accept next only when ready is 1; next in any other state or with key_ready=0 SHALL be ignored, with no queuing.
REQ-019 On accept, SHALL load state_out<=block_in, latch N=AES128_ROUNDS or AES256_ROUNDS per keylen, clear round and result_valid, and go to INIT.
REQ-020 In INIT, SHALL drive round_type=0 and round=0; on the edge, state_out<=state_new, round<=1, go to MAIN.
REQ-021 In MAIN, SHALL drive round_type=1; on each edge, state_out<=state_new and round<=round+1; go to FINAL when round==N-1.
REQ-022 In FINAL, SHALL drive round_type=2 and round=N; on the edge, result<=state_new, result_valid<=1, go to IDLE.
REQ-023 In IDLE, SHALL drive round_type=3 and hold round, state_out and result.
REQ-024 Latency: ready SHALL be 0 from the accept edge and SHALL return to 1 on the (N+1)th rising edge after it (11 for AES-128, 15 for AES-256), with result_valid rising on the same edge.
REQ-025 keylen and block_in changes during an operation SHALL have no effect.
REQ-026 key_ready falling mid-operation SHALL NOT abort the operation; it only gates the next accept.
REQ-027 round SHALL never exceed N, and the 4-bit counter SHALL never wrap.
REQ-028 next held high continuously SHALL start a new operation on the first edge with ready=1 after completion, clearing result_valid on that edge.

Reset
REQ-029 reset_n low SHALL immediately force FSM=IDLE, state_out=0, result=0, result_valid=0, round=0, round_type=3, N=AES128_ROUNDS, including mid-operation.
REQ-030 After reset release, ready SHALL equal key_ready, and no edge SHALL be lost.

Verification
REQ-031 Real datapath, key 000102030405060708090a0b0c0d0e0f, keylen=0, block 00112233445566778899aabbccddeeff, pulse next -> result 69c4e0d86a7b0430d8cdb78070b4c55a, result_valid after 11 edges.
REQ-032 Real datapath, key 000102...1f, keylen=1, same block -> result 8ea2b7ca516745bfeafc49904b496089 after 15 edges.
REQ-033 Stub state_new=state_out+1, block_in=0, keylen=0 -> round sequence 0,1..9,10, round_type 0,1x9,2, result=0x...0B.
REQ-034 Pulse next at cycle 5 of an operation, and with key_ready=0 while idle -> both ignored, result unchanged, ready stays as specified.
REQ-035 Assert reset_n=0 at round 6 -> outputs at reset values immediately; after release, a new operation completes correctly.
